// File: rtl/frequency_analyzer_pkg.sv
// frequency_analyzer_pkg
// Shared definitions for the multi-channel frequency analyser: the state
// encodings of the measurement and dump engines, the result_kind encoding and
// the helper that turns a target frequency into a period acceptance window.
package frequency_analyzer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } meas_state_e;

   typedef enum logic {
      D_IDLE = 1'b0,
      D_SEND = 1'b1
   } dump_state_e;

   // result_kind encoding: even stream words carry F1 time, odd words F2 time.
   localparam logic KIND_F1 = 1'b0;
   localparam logic KIND_F2 = 1'b1;

   // Period window bound in clock cycles. Every step truncates, so the window
   // is computed from the already truncated nominal period.
   function automatic longint unsigned window_bound(
      input longint unsigned clock_hz,
      input longint unsigned freq_hz,
      input longint unsigned deviation,
      input logic            upper
   );
      longint unsigned period;
      period = clock_hz / freq_hz;
      if (upper) begin
         return (period * (64'd100 + deviation)) / 64'd100;
      end else begin
         return (period * (64'd100 - deviation)) / 64'd100;
      end
   endfunction

endpackage

// File: rtl/frequency_channel.sv
// frequency_channel
// One monitored pixel: sample register, rising-edge detect, arming flag,
// saturating period counter, two-window classifier and two saturating
// accumulators.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   clear_i        zero accumulators, counter, sample state and arming
//   run_i          measurement enabled
//   disarm_i       entry into RUN; next edge only re-arms
//   hit_i          current beat is this channel's pixel (already gated by run)
//   bit_i          sampled bit of the current pixel
//   f1_acc_o/f2_acc_o  accumulated in-window time per target
module frequency_channel
   import frequency_analyzer_pkg::*;
#(
   parameter int                       COUNTER_WIDTH = 32,
   parameter logic [COUNTER_WIDTH-1:0] P1_LO = {COUNTER_WIDTH{1'b0}},
   parameter logic [COUNTER_WIDTH-1:0] P1_HI = {COUNTER_WIDTH{1'b0}},
   parameter logic [COUNTER_WIDTH-1:0] P2_LO = {COUNTER_WIDTH{1'b0}},
   parameter logic [COUNTER_WIDTH-1:0] P2_HI = {COUNTER_WIDTH{1'b0}}
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     run_i,
   input  logic                     disarm_i,
   input  logic                     hit_i,
   input  logic                     bit_i,
   output logic [COUNTER_WIDTH-1:0] f1_acc_o,
   output logic [COUNTER_WIDTH-1:0] f2_acc_o
);

   localparam logic [COUNTER_WIDTH-1:0] ALL_ONES = {COUNTER_WIDTH{1'b1}};
   localparam logic [COUNTER_WIDTH-1:0] ZERO     = {COUNTER_WIDTH{1'b0}};
   localparam logic [COUNTER_WIDTH-1:0] ONE      = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

   logic                     sample_q, sample_d;
   logic                     prev_q, prev_d;
   logic                     armed_q, armed_d;
   logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic [COUNTER_WIDTH-1:0] f1_q, f1_d;
   logic [COUNTER_WIDTH-1:0] f2_q, f2_d;
   logic [COUNTER_WIDTH-1:0] period_s;
   logic                     edge_s;

   function automatic logic [COUNTER_WIDTH-1:0] sat_add(
      input logic [COUNTER_WIDTH-1:0] a,
      input logic [COUNTER_WIDTH-1:0] b
   );
      logic [COUNTER_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[COUNTER_WIDTH]) begin
         return ALL_ONES;
      end else begin
         return sum[COUNTER_WIDTH-1:0];
      end
   endfunction

   // Edge detect and period measurement; the period includes the edge cycle itself.
   always_comb begin
      edge_s = sample_q & ~prev_q;
      if (cnt_q == ALL_ONES) begin
         period_s = cnt_q;
      end else begin
         period_s = cnt_q + ONE;
      end
   end

   // Next-state logic: clear beats everything, IDLE holds the measurement state.
   always_comb begin
      sample_d = sample_q;
      prev_d   = prev_q;
      armed_d  = armed_q;
      cnt_d    = cnt_q;
      f1_d     = f1_q;
      f2_d     = f2_q;
      if (clear_i) begin
         sample_d = 1'b0;
         prev_d   = 1'b0;
         armed_d  = 1'b0;
         cnt_d    = ZERO;
         f1_d     = ZERO;
         f2_d     = ZERO;
      end else if (run_i) begin
         prev_d = sample_q;
         if (hit_i) begin
            sample_d = bit_i;
         end else begin
            sample_d = sample_q;
         end
         if (edge_s) begin
            cnt_d = ZERO;
            if (!armed_q) begin
               armed_d = 1'b1;
            end else if (period_s >= P1_LO && period_s <= P1_HI) begin
               f1_d = sat_add(f1_q, period_s);
            end else if (period_s >= P2_LO && period_s <= P2_HI) begin
               f2_d = sat_add(f2_q, period_s);
            end else begin
               f1_d = f1_q;
            end
         end else begin
            cnt_d = period_s;
         end
      end else if (disarm_i) begin
         armed_d = 1'b0;
      end else begin
         armed_d = armed_q;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sample_q <= 1'b0;
         prev_q   <= 1'b0;
         armed_q  <= 1'b0;
         cnt_q    <= ZERO;
         f1_q     <= ZERO;
         f2_q     <= ZERO;
      end else begin
         sample_q <= sample_d;
         prev_q   <= prev_d;
         armed_q  <= armed_d;
         cnt_q    <= cnt_d;
         f1_q     <= f1_d;
         f2_q     <= f2_d;
      end
   end

   assign f1_acc_o = f1_q;
   assign f2_acc_o = f2_q;

endmodule

// File: rtl/multi_channel_frequency_analyzer.sv
// multi_channel_frequency_analyzer
// Samples one bit of CHANNELS programmable pixel positions per video line,
// measures rising-edge periods, accumulates in-window time per target
// frequency and streams an accumulator snapshot on a valid/ready port.
// Ports:
//   clock, reset                          clock, synchronous active-high reset
//   pixel_data/pixel_valid/line_start     pixel capture stream
//   cfg_write/cfg_channel/cfg_index       per-channel pixel position
//   start/stop/clear/dump_request         single-cycle commands
//   result_*                              snapshot stream (valid/ready)
//   running/dumping/irq                   status and dump-complete pulse
module multi_channel_frequency_analyzer
   import frequency_analyzer_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int SAMPLE_BIT    = 7,
   parameter int LINE_LENGTH   = 1024,
   parameter int INDEX_WIDTH   = 10,
   parameter int COUNTER_WIDTH = 32,
   parameter int CLOCK         = 100000000,
   parameter int FREQUENCY_1   = 9000,
   parameter int FREQUENCY_2   = 11000,
   parameter int DEVIATION     = 10,
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [DATA_WIDTH-1:0]    pixel_data,
   input  logic                     pixel_valid,
   input  logic                     line_start,
   input  logic                     cfg_write,
   input  logic [CH_W-1:0]          cfg_channel,
   input  logic [INDEX_WIDTH-1:0]   cfg_index,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     clear,
   input  logic                     dump_request,
   output logic                     result_valid,
   input  logic                     result_ready,
   output logic [COUNTER_WIDTH-1:0] result_data,
   output logic [CH_W-1:0]          result_channel,
   output logic                     result_kind,
   output logic                     result_last,
   output logic                     running,
   output logic                     dumping,
   output logic                     irq
);

   localparam int PTR_W = CH_W + 1;
   localparam int WORDS = 2 * CHANNELS;

   localparam logic [COUNTER_WIDTH-1:0] P1_LO = COUNTER_WIDTH'(window_bound(64'(CLOCK), 64'(FREQUENCY_1), 64'(DEVIATION), 1'b0));
   localparam logic [COUNTER_WIDTH-1:0] P1_HI = COUNTER_WIDTH'(window_bound(64'(CLOCK), 64'(FREQUENCY_1), 64'(DEVIATION), 1'b1));
   localparam logic [COUNTER_WIDTH-1:0] P2_LO = COUNTER_WIDTH'(window_bound(64'(CLOCK), 64'(FREQUENCY_2), 64'(DEVIATION), 1'b0));
   localparam logic [COUNTER_WIDTH-1:0] P2_HI = COUNTER_WIDTH'(window_bound(64'(CLOCK), 64'(FREQUENCY_2), 64'(DEVIATION), 1'b1));

   localparam logic [INDEX_WIDTH-1:0] IDX_ZERO = {INDEX_WIDTH{1'b0}};
   localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [INDEX_WIDTH-1:0] IDX_LAST = INDEX_WIDTH'(LINE_LENGTH - 1);
   localparam logic [PTR_W-1:0]       PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(WORDS - 1);

   logic [INDEX_WIDTH-1:0]   pix_cnt_q, pix_cnt_d, beat_idx_s;
   logic [INDEX_WIDTH-1:0]   idx_q [CHANNELS];
   logic [INDEX_WIDTH-1:0]   idx_d [CHANNELS];
   meas_state_e              meas_q, meas_d;
   logic                     disarm_s, run_s;
   logic [CHANNELS-1:0]      hit_s;
   logic [COUNTER_WIDTH-1:0] acc_f1_s [CHANNELS];
   logic [COUNTER_WIDTH-1:0] acc_f2_s [CHANNELS];
   logic [COUNTER_WIDTH-1:0] shadow_q [WORDS];
   logic [COUNTER_WIDTH-1:0] shadow_d [WORDS];
   dump_state_e              dump_q, dump_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic                     valid_q, valid_d, last_q, last_d, irq_q, irq_d;
   logic [COUNTER_WIDTH-1:0] data_q, data_d;
   logic                     unused_pixel_bits_s;

   // Only SAMPLE_BIT of the pixel is observed.
   assign unused_pixel_bits_s = ^pixel_data;

   // Pixel position tracking, index configuration and run control.
   always_comb begin
      pix_cnt_d = pix_cnt_q;
      idx_d     = idx_q;
      meas_d    = meas_q;
      disarm_s  = 1'b0;
      if (line_start) begin
         beat_idx_s = IDX_ZERO;
      end else begin
         beat_idx_s = pix_cnt_q;
      end
      if (pixel_valid) begin
         if (line_start) begin
            pix_cnt_d = IDX_ONE;
         end else if (pix_cnt_q == IDX_LAST) begin
            pix_cnt_d = IDX_ZERO;
         end else begin
            pix_cnt_d = pix_cnt_q + IDX_ONE;
         end
      end else begin
         pix_cnt_d = pix_cnt_q;
      end
      // Out-of-range cfg_channel values match no channel and are dropped.
      for (int c = 0; c < CHANNELS; c++) begin
         if (cfg_write && cfg_channel == CH_W'(c)) begin
            idx_d[c] = cfg_index;
         end else begin
            idx_d[c] = idx_q[c];
         end
      end
      case (meas_q)
         IDLE: begin
            if (start && !stop) begin
               meas_d   = RUN;
               disarm_s = 1'b1;
            end else begin
               meas_d = IDLE;
            end
         end
         RUN: begin
            if (stop) begin
               meas_d = IDLE;
            end else begin
               meas_d = RUN;
            end
         end
         default: meas_d = IDLE;
      endcase
   end

   assign run_s = (meas_q == RUN);

   // Channel hit: running and the current beat is the channel's pixel.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         hit_s[c] = pixel_valid & run_s & (beat_idx_s == idx_q[c]);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      frequency_channel #(
         .COUNTER_WIDTH (COUNTER_WIDTH),
         .P1_LO         (P1_LO),
         .P1_HI         (P1_HI),
         .P2_LO         (P2_LO),
         .P2_HI         (P2_HI)
      ) u_channel (
         .clk_i    (clock),
         .rst_i    (reset),
         .clear_i  (clear),
         .run_i    (run_s),
         .disarm_i (disarm_s),
         .hit_i    (hit_s[g]),
         .bit_i    (pixel_data[SAMPLE_BIT]),
         .f1_acc_o (acc_f1_s[g]),
         .f2_acc_o (acc_f2_s[g])
      );
   end

   // Dump engine: snapshot on request, then one word per accepted transfer.
   always_comb begin
      dump_d   = dump_q;
      shadow_d = shadow_q;
      ptr_d    = ptr_q;
      valid_d  = valid_q;
      data_d   = data_q;
      last_d   = last_q;
      irq_d    = 1'b0;
      case (dump_q)
         D_IDLE: begin
            if (dump_request) begin
               dump_d = D_SEND;
               for (int c = 0; c < CHANNELS; c++) begin
                  shadow_d[2*c]   = acc_f1_s[c];
                  shadow_d[2*c+1] = acc_f2_s[c];
               end
               // The shadow is still loading, so word 0 comes straight from the live value.
               ptr_d   = {PTR_W{1'b0}};
               valid_d = 1'b1;
               data_d  = acc_f1_s[0];
               last_d  = 1'b0;
            end else begin
               dump_d = D_IDLE;
            end
         end
         D_SEND: begin
            if (valid_q && result_ready) begin
               if (last_q) begin
                  dump_d  = D_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  data_d  = {COUNTER_WIDTH{1'b0}};
                  ptr_d   = {PTR_W{1'b0}};
                  irq_d   = 1'b1;
               end else begin
                  ptr_d  = ptr_q + PTR_ONE;
                  data_d = shadow_q[ptr_d];
                  last_d = (ptr_d == PTR_LAST);
               end
            end else begin
               dump_d = D_SEND;
            end
         end
         default: dump_d = D_IDLE;
      endcase
   end

   // Top-level state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         pix_cnt_q <= IDX_ZERO;
         meas_q    <= IDLE;
         dump_q    <= D_IDLE;
         ptr_q     <= {PTR_W{1'b0}};
         valid_q   <= 1'b0;
         data_q    <= {COUNTER_WIDTH{1'b0}};
         last_q    <= 1'b0;
         irq_q     <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            idx_q[c] <= IDX_ZERO;
         end
         for (int w = 0; w < WORDS; w++) begin
            shadow_q[w] <= {COUNTER_WIDTH{1'b0}};
         end
      end else begin
         pix_cnt_q <= pix_cnt_d;
         meas_q    <= meas_d;
         dump_q    <= dump_d;
         ptr_q     <= ptr_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         last_q    <= last_d;
         irq_q     <= irq_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
      end
   end

   assign result_valid   = valid_q;
   assign result_data    = data_q;
   assign result_channel = ptr_q[PTR_W-1:1];
   assign result_kind    = ptr_q[0] ? KIND_F2 : KIND_F1;
   assign result_last    = last_q;
   assign running        = (meas_q == RUN);
   assign dumping        = (dump_q == D_SEND);
   assign irq            = irq_q;

endmodule

// File: tb/tb_multi_channel_frequency_analyzer.sv
// Directed bench: CLOCK=1000, F1=100, F2=125, DEVIATION=10 gives an F1
// window of [9,11] and an F2 window of [7,8]; LINE_LENGTH=4, CHANNELS=2 and
// 8-bit counters so that saturation is reachable.
module tb_multi_channel_frequency_analyzer;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] pixel_data;
   logic       pixel_valid, line_start;
   logic       cfg_write;
   logic [0:0] cfg_channel;
   logic [1:0] cfg_index;
   logic       start, stop, clear, dump_request;
   logic       result_valid, result_ready;
   logic [7:0] result_data;
   logic [0:0] result_channel;
   logic       result_kind, result_last, running, dumping, irq;

   int checks   = 0;
   int failures = 0;

   multi_channel_frequency_analyzer #(
      .CHANNELS(2), .DATA_WIDTH(8), .SAMPLE_BIT(7), .LINE_LENGTH(4),
      .INDEX_WIDTH(2), .COUNTER_WIDTH(8), .CLOCK(1000),
      .FREQUENCY_1(100), .FREQUENCY_2(125), .DEVIATION(10)
   ) dut (
      .clock(clock), .reset(reset), .pixel_data(pixel_data),
      .pixel_valid(pixel_valid), .line_start(line_start),
      .cfg_write(cfg_write), .cfg_channel(cfg_channel), .cfg_index(cfg_index),
      .start(start), .stop(stop), .clear(clear), .dump_request(dump_request),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_data(result_data), .result_channel(result_channel),
      .result_kind(result_kind), .result_last(result_last),
      .running(running), .dumping(dumping), .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One 4-pixel line; mask bit k drives SAMPLE_BIT of pixel k, other bits are the inverse.
   task automatic send_line(input logic [3:0] mask, input int clr_beat, input int idle);
      for (int k = 0; k < 4; k++) begin
         pixel_valid = 1'b1;
         line_start  = (k == 0);
         pixel_data  = mask[k] ? 8'h80 : 8'h7F;
         clear       = (k == clr_beat);
         tick();
      end
      pixel_valid = 1'b0;
      line_start  = 1'b0;
      pixel_data  = 8'h00;
      clear       = 1'b0;
      for (int k = 0; k < idle; k++) tick();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Request a dump and check the four words; exp byte w is word w.
   task automatic do_dump(input string tag, input logic [31:0] exp, input bit rnd_ready);
      int idx;
      int cyc;
      logic [7:0] w;
      dump_request = 1'b1;
      tick();
      dump_request = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 200) begin
         result_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         w = exp[idx*8 +: 8];
         check({tag, " valid"}, 32'(result_valid), 32'd1);
         check({tag, " dumping"}, 32'(dumping), 32'd1);
         check({tag, " data"}, 32'(result_data), 32'(w));
         check({tag, " channel"}, 32'(result_channel), 32'(idx / 2));
         check({tag, " kind"}, 32'(result_kind), 32'(idx % 2));
         check({tag, " last"}, 32'(result_last), 32'(idx == 3));
         check({tag, " irq_early"}, 32'(irq), 32'd0);
         if (result_ready) idx++;
         tick();
         cyc++;
      end
      check({tag, " timeout"}, 32'(idx), 32'd4);
      result_ready = 1'b0;
      check({tag, " irq"}, 32'(irq), 32'd1);
      check({tag, " dumping_end"}, 32'(dumping), 32'd0);
      check({tag, " valid_end"}, 32'(result_valid), 32'd0);
      tick();
      check({tag, " irq_pulse"}, 32'(irq), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; pixel_data = 8'h00; pixel_valid = 1'b0; line_start = 1'b0;
      cfg_write = 1'b0; cfg_channel = 1'b0; cfg_index = 2'd0;
      start = 1'b0; stop = 1'b0; clear = 1'b0; dump_request = 1'b0; result_ready = 1'b0;
      tick();
      tick();
      check("rst valid", 32'(result_valid), 32'd0);
      check("rst data", 32'(result_data), 32'd0);
      check("rst channel", 32'(result_channel), 32'd0);
      check("rst kind", 32'(result_kind), 32'd0);
      check("rst last", 32'(result_last), 32'd0);
      check("rst running", 32'(running), 32'd0);
      check("rst dumping", 32'(dumping), 32'd0);
      check("rst irq", 32'(irq), 32'd0);
      reset = 1'b0;
      tick();

      // start and stop together from IDLE: stop wins
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("start_stop running", 32'(running), 32'd0);

      cfg_write = 1'b1; cfg_channel = 1'b1; cfg_index = 2'd2;
      tick();
      cfg_write = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start running", 32'(running), 32'd1);

      // period 8 on ch0: first edge arms, four armed edges of 8 land in F2
      for (int r = 0; r < 5; r++) begin
         send_line(4'b0001, -1, 0);
         send_line(4'b0000, -1, 0);
      end
      do_dump("p8", 32'h0000_2000, 1'b0);

      // period 12 on ch1: outside both windows
      pulse_clear();
      for (int r = 0; r < 4; r++) begin
         send_line(4'b0100, -1, 0);
         send_line(4'b0000, -1, 0);
         send_line(4'b0000, -1, 0);
      end
      do_dump("p12", 32'h0000_0000, 1'b0);

      // period 10 on ch1 (one idle cycle per line): three armed edges into F1
      pulse_clear();
      for (int r = 0; r < 4; r++) begin
         send_line(4'b0100, -1, 1);
         send_line(4'b0000, -1, 1);
      end
      do_dump("p10", 32'h001E_0000, 1'b1);

      // clear in the cycle of an armed edge: nothing accumulated
      pulse_clear();
      send_line(4'b0001, -1, 0);
      send_line(4'b0000, -1, 0);
      send_line(4'b0001, 1, 0);
      send_line(4'b0000, -1, 0);
      do_dump("clr_edge", 32'h0000_0000, 1'b0);

      // 33 armed edges of 8 = 264 saturates the 8-bit F2 accumulator
      pulse_clear();
      for (int r = 0; r < 34; r++) begin
         send_line(4'b0001, -1, 0);
         send_line(4'b0000, -1, 0);
      end
      do_dump("sat", 32'h0000_FF00, 1'b0);

      // reset in the middle of a dump
      dump_request = 1'b1;
      tick();
      dump_request = 1'b0;
      check("mid valid_before", 32'(result_valid), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid valid", 32'(result_valid), 32'd0);
      check("mid dumping", 32'(dumping), 32'd0);
      check("mid irq", 32'(irq), 32'd0);
      check("mid running", 32'(running), 32'd0);
      tick();
      check("mid irq_after", 32'(irq), 32'd0);
      do_dump("post_rst", 32'h0000_0000, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
